ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port 16-bit program/data RAM between two requesters: CPU (instruction fetch +
//  load/store) and DBG (program loader / debug port). Sits between cpu/controller and ram; a denied CPU
//  request stalls the controller (cpu_gnt=0 drives its waiting input). One RAM access per cycle;
//  round-robin on contention, with a bounded DBG burst lock.
// PARAMETERS
//  ADDR_W    8   RAM address width
//  DATA_W    16  RAM data width
//  MAX_HOLD  4   max consecutive grants to one requester while the other waits (>=1)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       reset, asynchronous, active-high
//  cpu_req     in   1       CPU access request (held until granted)
//  cpu_we      in   1       1=write, 0=read
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_gnt     out  1       access issued to RAM this cycle (combinational)
//  cpu_rvalid  out  1       read data valid for CPU (registered)
//  cpu_rdata   out  DATA_W  = ram_r_data
//  dbg_req     in   1       DBG access request
//  dbg_lock    in   1       DBG requests back-to-back ownership (burst)
//  dbg_we      in   1       1=write, 0=read
//  dbg_addr    in   ADDR_W  DBG address
//  dbg_wdata   in   DATA_W  DBG write data
//  dbg_gnt     out  1       as cpu_gnt
//  dbg_rvalid  out  1       as cpu_rvalid
//  dbg_rdata   out  DATA_W  = ram_r_data
//  ram_w_en    out  1       RAM write enable
//  ram_r_addr  out  ADDR_W  RAM read address
//  ram_w_addr  out  ADDR_W  RAM write address (= ram_r_addr)
//  ram_w_data  out  DATA_W  RAM write data
//  ram_r_data  in   DATA_W  RAM read data, valid 1 cycle after address (sync read)
// BEHAVIOUR
//  Reset (async): last_owner=CPU, hold_cnt=0, both rvalid=0. While rst=1: gnt=0, ram_w_en=0.
//  Grant (comb, per cycle, at most one):
//   - only one req -> grant it.
//   - both req: if hold_cnt==MAX_HOLD -> grant the non-last_owner (forced switch);
//     else if last_owner==DBG && dbg_lock -> DBG; else grant the non-last_owner (round-robin).
//   - neither -> no grant, ram_w_en=0, address muxes hold winner-less default (CPU path).
//  Issue: granted requester's addr/wdata/we drive RAM same cycle; ram_w_en = gnt & we.
//  Counters (on posedge, when a grant occurs): same owner as last -> hold_cnt=min(hold_cnt+1,MAX_HOLD);
//   owner change -> hold_cnt=1, last_owner=new. No grant cycle -> hold_cnt=0, last_owner kept.
//  Read return: x_rvalid <= x_gnt & ~x_we; exactly 1 cycle latency; write gives no rvalid.
//  Requester holds req/addr/we/wdata stable until gnt; may drop req after gnt cycle.
//  Same-address write then read in next cycle returns new data (RAM write-first into next read).
//  Reset mid-read: pending rvalid is dropped (0), never asserted after rst deasserts.
//  dbg_lock ignored when DBG not requesting; lock cannot starve CPU beyond MAX_HOLD cycles.
// STRUCTURE
//  Package ram_arb_pkg: typedef enum logic {OWN_CPU, OWN_DBG} owner_t; MAX_HOLD default constant.
//  Single flat module: comb grant/mux block + one always_ff (last_owner, hold_cnt, rvalids).
//  No sub-module; hold_cnt width = $clog2(MAX_HOLD+1).
// TESTING
//  1 Reset: rst=1 with both req=1 -> both gnt=0, ram_w_en=0, rvalid=0; release -> CPU granted first.
//  2 Solo CPU read addr 8'h10 (RAM holds 16'hBEEF) -> cpu_gnt same cycle, cpu_rvalid=1, rdata=BEEF next.
//  3 Both req continuously, no lock -> grants alternate CPU,DBG,CPU,DBG...; each rvalid goes to owner.
//  4 DBG lock burst, CPU req held, MAX_HOLD=4 -> DBG granted 4 cycles, then CPU 1, then DBG again.
//  5 DBG writes 16'h1234 @8'h20, CPU reads 8'h20 next cycle -> cpu_rdata=16'h1234, no dbg_rvalid.
//  6 Assert rst the cycle after a CPU read grant -> cpu_rvalid stays 0 through and after reset.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and defaults for the CPU/DBG RAM port arbiter.
package ram_arb_pkg;

   // Requester that most recently owned the RAM port
   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DBG = 1'b1
   } owner_t;

   localparam int unsigned ADDR_W_DEF   = 8;
   localparam int unsigned DATA_W_DEF   = 16;
   localparam int unsigned MAX_HOLD_DEF = 4;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the CPU port, DBG port and RAM port seen by the arbiter.
interface ram_port_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
);
   // CPU requester
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   // DBG requester
   logic              dbg_req;
   logic              dbg_lock;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;
   // RAM side
   logic              ram_w_en;
   logic [ADDR_W-1:0] ram_r_addr;
   logic [ADDR_W-1:0] ram_w_addr;
   logic [DATA_W-1:0] ram_w_data;
   logic [DATA_W-1:0] ram_r_data;

   // Arbiter view
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output ram_w_en, ram_r_addr, ram_w_addr, ram_w_data,
      input  ram_r_data
   );

   // Requester/RAM environment view
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  ram_w_en, ram_r_addr, ram_w_addr, ram_w_data,
      output ram_r_data
   );

endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single-port program/data RAM.
// One access per cycle; round-robin on contention, with a DBG burst lock
// bounded by MAX_HOLD consecutive grants while the CPU waits.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic              clk,
   input  logic              rst,
   ram_port_arbiter_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

   owner_t            last_owner;
   logic [CNT_W-1:0]  hold_cnt;
   logic              gnt_cpu;
   logic              gnt_dbg;
   logic              gnt_any;
   owner_t            new_owner;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              cpu_rvalid_q;
   logic              dbg_rvalid_q;

   // Grant decision: at most one requester per cycle, nothing during reset
   always_comb begin
      gnt_cpu = 1'b0;
      gnt_dbg = 1'b0;
      if (!rst) begin
         if (bus.cpu_req && !bus.dbg_req) begin
            gnt_cpu = 1'b1;
         end else if (bus.dbg_req && !bus.cpu_req) begin
            gnt_dbg = 1'b1;
         end else if (bus.cpu_req && bus.dbg_req) begin
            // Forced switch beats the lock, so the CPU never waits past MAX_HOLD
            if (hold_cnt != HOLD_MAX && last_owner == OWN_DBG && bus.dbg_lock) begin
               gnt_dbg = 1'b1;
            end else if (last_owner == OWN_CPU) begin
               gnt_dbg = 1'b1;
            end else begin
               gnt_cpu = 1'b1;
            end
         end
      end
   end

   // RAM port mux: CPU path is the default when nobody is granted
   always_comb begin
      sel_we    = bus.cpu_we;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
      if (gnt_dbg) begin
         sel_we    = bus.dbg_we;
         sel_addr  = bus.dbg_addr;
         sel_wdata = bus.dbg_wdata;
      end
   end

   assign gnt_any   = gnt_cpu | gnt_dbg;
   assign new_owner = gnt_dbg ? OWN_DBG : OWN_CPU;

   assign bus.cpu_gnt    = gnt_cpu;
   assign bus.dbg_gnt    = gnt_dbg;
   assign bus.ram_w_en   = gnt_any & sel_we;
   assign bus.ram_r_addr = sel_addr;
   assign bus.ram_w_addr = sel_addr;
   assign bus.ram_w_data = sel_wdata;
   assign bus.cpu_rdata  = bus.ram_r_data;
   assign bus.dbg_rdata  = bus.ram_r_data;
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.dbg_rvalid = dbg_rvalid_q;

   // Ownership history, saturating hold counter and read-return flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_owner   <= OWN_CPU;
         hold_cnt     <= '0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
      end else begin
         if (gnt_any) begin
            if (new_owner == last_owner) begin
               if (hold_cnt != HOLD_MAX) begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end else begin
               hold_cnt   <= CNT_W'(1);
               last_owner <= new_owner;
            end
         end else begin
            hold_cnt <= '0;
         end
         cpu_rvalid_q <= gnt_cpu & ~bus.cpu_we;
         dbg_rvalid_q <= gnt_dbg & ~bus.dbg_we;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized self-checking bench for ram_port_arbiter with a behavioural
// sync-read RAM and a transaction-level reference model.
module tb_ram_port_arbiter;

   localparam int MAX_HOLD = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ram_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

   ram_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_HOLD(MAX_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: synchronous read, writes visible to the next read
   logic [15:0] ram [256];
   always @(posedge clk) begin
      if (bus.ram_w_en) ram[bus.ram_w_addr] <= bus.ram_w_data;
      bus.ram_r_data <= ram[bus.ram_r_addr];
   end

   // Reference model state (owner: 1=CPU, 2=DBG; run = consecutive grants)
   logic [15:0] mem_m [256];
   int          m_last = 1;
   int          m_run  = 0;
   logic        exp_crv = 1'b0;
   logic        exp_drv = 1'b0;
   logic [15:0] exp_rdata = '0;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check, then advance the model
   task automatic cycle(input logic r,
                        input logic cq, input logic cw, input logic [7:0] ca, input logic [15:0] cd,
                        input logic dq, input logic dl, input logic dw, input logic [7:0] da,
                        input logic [15:0] dd, output int g);
      int other;
      logic exp_wen;
      @(negedge clk);
      rst           = r;
      bus.cpu_req   = cq;  bus.cpu_we = cw;  bus.cpu_addr = ca;  bus.cpu_wdata = cd;
      bus.dbg_req   = dq;  bus.dbg_lock = dl; bus.dbg_we = dw;
      bus.dbg_addr  = da;  bus.dbg_wdata = dd;
      #1;
      other = (m_last == 1) ? 2 : 1;
      g = 0;
      if (r) begin
         exp_crv = 1'b0;
         exp_drv = 1'b0;
      end else if (cq && !dq) g = 1;
      else if (dq && !cq) g = 2;
      else if (cq && dq) begin
         if (m_run >= MAX_HOLD)             g = other;
         else if (m_last == 2 && dl)        g = 2;
         else                               g = other;
      end
      exp_wen = (g == 1 && cw) || (g == 2 && dw);
      check("cpu_gnt", 32'(bus.cpu_gnt), 32'(g == 1));
      check("dbg_gnt", 32'(bus.dbg_gnt), 32'(g == 2));
      check("ram_w_en", 32'(bus.ram_w_en), 32'(exp_wen));
      check("ram_r_addr", 32'(bus.ram_r_addr), 32'((g == 2) ? da : ca));
      check("ram_w_addr", 32'(bus.ram_w_addr), 32'((g == 2) ? da : ca));
      if (exp_wen) check("ram_w_data", 32'(bus.ram_w_data), 32'((g == 2) ? dd : cd));
      check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(exp_crv));
      check("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(exp_drv));
      if (exp_crv) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_rdata));
      if (exp_drv) check("dbg_rdata", 32'(bus.dbg_rdata), 32'(exp_rdata));
      // Advance model to the state after the coming posedge
      if (r) begin
         m_last = 1;
         m_run  = 0;
      end else begin
         exp_crv = (g == 1) && !cw;
         exp_drv = (g == 2) && !dw;
         if (g == 1) begin
            if (cw) mem_m[ca] = cd; else exp_rdata = mem_m[ca];
         end else if (g == 2) begin
            if (dw) mem_m[da] = dd; else exp_rdata = mem_m[da];
         end
         if (g == 0)           m_run = 0;
         else if (g == m_last) m_run++;
         else begin
            m_run  = 1;
            m_last = g;
         end
      end
   endtask

   task automatic idle(input logic r, output int g);
      cycle(r, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, g);
   endtask

   initial begin
      int g;
      logic [11:0] seq;
      logic        cp, cw, dp, dw, dl;
      logic [7:0]  ca, da;
      logic [15:0] cd, dd;

      for (int i = 0; i < 256; i++) begin
         ram[i]   = 16'($urandom);
         mem_m[i] = ram[i];
      end
      ram[8'h10]   = 16'hBEEF;
      mem_m[8'h10] = 16'hBEEF;

      // Reset with both requesting: no grants, no write, no rvalid
      cycle(1'b1, 1'b1, 1'b1, 8'h01, 16'h1111, 1'b1, 1'b1, 1'b1, 8'h02, 16'h2222, g);
      cycle(1'b1, 1'b1, 1'b0, 8'h01, 16'h1111, 1'b1, 1'b0, 1'b0, 8'h02, 16'h2222, g);

      // Solo CPU read of 0x10 right after release
      cycle(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, g);
      check("t2_gnt", 32'(g), 32'd1);
      idle(1'b0, g);
      check("t2_rdata", 32'(bus.cpu_rdata), 32'h0000BEEF);

      // Continuous contention without lock alternates owners
      seq = '0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 8'(i), 16'h0, 1'b1, 1'b0, 1'b0, 8'(i + 8), 16'h0, g);
         seq = {seq[9:0], 2'(g)};
      end
      check("t3_alternate", 32'(seq), 32'b10_01_10_01_10_01);
      idle(1'b0, g);

      // DBG locked burst against a waiting CPU
      seq = '0;
      cycle(1'b0, 1'b0, 1'b0, 8'h30, 16'h0, 1'b1, 1'b1, 1'b0, 8'h40, 16'h0, g);
      seq = {seq[9:0], 2'(g)};
      cp = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, cp, 1'b0, 8'h30, 16'h0, 1'b1, 1'b1, 1'b0, 8'(8'h41 + i), 16'h0, g);
         if (g == 1) cp = 1'b0;
         seq = {seq[9:0], 2'(g)};
      end
      check("t4_burst", 32'(seq), 32'hAA6);
      idle(1'b0, g);

      // DBG write then CPU read of the same address
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 1'b1, 8'h20, 16'h1234, g);
      cycle(1'b0, 1'b1, 1'b0, 8'h20, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, g);
      idle(1'b0, g);
      check("t5_rdata", 32'(bus.cpu_rdata), 32'h00001234);
      check("t5_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);

      // Reset the cycle after a CPU read grant drops the pending rvalid
      cycle(1'b0, 1'b1, 1'b0, 8'h10, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, g);
      idle(1'b1, g);
      idle(1'b1, g);
      idle(1'b0, g);
      idle(1'b0, g);

      // Randomized traffic; requests stay stable until granted
      cp = 1'b0; dp = 1'b0;
      cw = 1'b0; dw = 1'b0; ca = '0; da = '0; cd = '0; dd = '0;
      for (int n = 0; n < 400; n++) begin
         if (!cp && $urandom_range(0, 2) != 0) begin
            cp = 1'b1; cw = 1'($urandom); ca = 8'($urandom_range(0, 15)); cd = 16'($urandom);
         end
         if (!dp && $urandom_range(0, 2) != 0) begin
            dp = 1'b1; dw = 1'($urandom); da = 8'($urandom_range(0, 15)); dd = 16'($urandom);
         end
         dl = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) == 0) begin
            cycle(1'b1, cp, cw, ca, cd, dp, dl, dw, da, dd, g);
         end else begin
            cycle(1'b0, cp, cw, ca, cd, dp, dl, dw, da, dd, g);
         end
         if (g == 1) cp = 1'b0;
         if (g == 2) dp = 1'b0;
      end
      idle(1'b0, g);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
